// File: rtl/addr_map_ctrl_pkg.sv
// Shared types for the address-map controller.
//   field_e : config field selector (idx / start_addr / end_addr / reserved)
//   state_e : commit FSM states
//   rule_t  : one map rule at default widths. The top's flat addr_map_o bus
//             uses the same bit order per rule: idx in the MSBs, then
//             start_addr, then end_addr in the LSBs.
package addr_map_ctrl_pkg;

  typedef enum logic [1:0] {
    FIELD_IDX   = 2'd0,
    FIELD_START = 2'd1,
    FIELD_END   = 2'd2,
    FIELD_RSVD  = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int DefAddrWidth = 32;
  localparam int DefIdxWidth  = 2;

  typedef struct packed {
    logic [DefIdxWidth-1:0]  idx;
    logic [DefAddrWidth-1:0] start_addr;
    logic [DefAddrWidth-1:0] end_addr;
  } rule_t;

  // Width of an index into n items; never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addr_map_rule_check.sv
// Combinational validator for a complete rule map.
//   rules_i    : NoRules rules, flat, rule r at [r*RuleWidth +: RuleWidth]
//   rule_err_o : per-rule error (start_addr >= end_addr or idx >= NoIndices)
//   ok_o       : no rule in error
module addr_map_rule_check #(
  parameter int NoRules   = 4,
  parameter int NoIndices = 4,
  parameter int AddrWidth = 32,
  parameter int IdxWidth  = 2,
  parameter int RuleWidth = IdxWidth + 2 * AddrWidth
) (
  input  logic [NoRules*RuleWidth-1:0] rules_i,
  output logic [NoRules-1:0]           rule_err_o,
  output logic                         ok_o
);

  for (genvar r = 0; r < NoRules; r++) begin : g_rule
    logic [IdxWidth-1:0]  w_idx;
    logic [AddrWidth-1:0] w_start;
    logic [AddrWidth-1:0] w_end;

    assign w_idx   = rules_i[r*RuleWidth + 2*AddrWidth +: IdxWidth];
    assign w_start = rules_i[r*RuleWidth + AddrWidth +: AddrWidth];
    assign w_end   = rules_i[r*RuleWidth +: AddrWidth];

    assign rule_err_o[r] = (w_start >= w_end) || (int'(w_idx) >= NoIndices);
  end

  assign ok_o = ~|rule_err_o;

endmodule

// File: rtl/addr_map_ctrl.sv
// Address-map controller: software edits a shadow copy of the map through a
// config port; a commit drains outstanding datapath transactions, validates
// the shadow map, and atomically copies it to the active map.
//   clk_i, rst_i                : clock, async active-high reset
//   cfg_req_i/we_i/rule_i/field_i/wdata_i -> cfg_gnt_o, cfg_rvalid_o/rdata_o
//   commit_req_i -> commit_done_o / commit_err_o (one-cycle pulses)
//   txn_start_i/txn_end_i       : outstanding transaction tracking
//   block_o                     : datapath must not issue while high
//   addr_map_o, map_valid_o     : active map (rule_t layout per rule)
//   dbg_state_o, dbg_count_o    : FSM state and outstanding count
// Handshake: a config access is accepted in any cycle where cfg_req_i and
// cfg_gnt_o are both high; a read's data returns with cfg_rvalid_o exactly
// one cycle after acceptance. No back-pressure on the response.
module addr_map_ctrl
  import addr_map_ctrl_pkg::*;
#(
  parameter int NoRules        = 4,
  parameter int NoIndices      = 4,
  parameter int AddrWidth      = 32,
  parameter int MaxOutstanding = 8,
  localparam int RuleSelW  = clog2_min1(NoRules),
  localparam int IdxWidth  = clog2_min1(NoIndices),
  localparam int CntWidth  = $clog2(MaxOutstanding + 1),
  localparam int RuleWidth = IdxWidth + 2 * AddrWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_req_i,
  input  logic                         cfg_we_i,
  input  logic [RuleSelW-1:0]          cfg_rule_i,
  input  logic [1:0]                   cfg_field_i,
  input  logic [AddrWidth-1:0]         cfg_wdata_i,
  output logic                         cfg_gnt_o,
  output logic                         cfg_rvalid_o,
  output logic [AddrWidth-1:0]         cfg_rdata_o,
  input  logic                         commit_req_i,
  output logic                         commit_done_o,
  output logic                         commit_err_o,
  input  logic                         txn_start_i,
  input  logic                         txn_end_i,
  output logic                         block_o,
  output logic [NoRules*RuleWidth-1:0] addr_map_o,
  output logic                         map_valid_o,
  output logic [1:0]                   dbg_state_o,
  output logic [CntWidth-1:0]          dbg_count_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  state_e               r_state, w_state_next;
  logic                 w_gnt, w_block;
  logic [CntWidth-1:0]  r_count;

  logic [IdxWidth-1:0]  r_sh_idx   [NoRules];
  logic [AddrWidth-1:0] r_sh_start [NoRules];
  logic [AddrWidth-1:0] r_sh_end   [NoRules];
  logic [IdxWidth-1:0]  r_act_idx  [NoRules];
  logic [AddrWidth-1:0] r_act_start[NoRules];
  logic [AddrWidth-1:0] r_act_end  [NoRules];

  logic                 r_rvalid, r_done, r_err, r_map_valid;
  logic [AddrWidth-1:0] r_rdata, w_rd_data;

  logic [NoRules*RuleWidth-1:0] w_shadow_flat;
  logic [NoRules-1:0]           w_rule_err;
  logic                         w_check_ok;
  logic                         w_rule_in_range;
  field_e                       w_field;

  assign w_field         = field_e'(cfg_field_i);
  assign w_rule_in_range = int'(cfg_rule_i) < NoRules;

  for (genvar r = 0; r < NoRules; r++) begin : g_flat
    assign w_shadow_flat[r*RuleWidth +: RuleWidth] = {r_sh_idx[r], r_sh_start[r], r_sh_end[r]};
    assign addr_map_o[r*RuleWidth +: RuleWidth]    = {r_act_idx[r], r_act_start[r], r_act_end[r]};
  end

  addr_map_rule_check #(
    .NoRules  (NoRules),
    .NoIndices(NoIndices),
    .AddrWidth(AddrWidth),
    .IdxWidth (IdxWidth)
  ) u_rule_check (
    .rules_i   (w_shadow_flat),
    .rule_err_o(w_rule_err),
    .ok_o      (w_check_ok)
  );

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and state-decoded outputs. Grant is masked by reset so the
  // port is quiet while reset is held.
  always_comb begin
    w_state_next = r_state;
    w_gnt        = 1'b0;
    w_block      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gnt   = cfg_req_i & ~rst_i;
        w_block = (r_count == CntMax);
        if (commit_req_i) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_block = 1'b1;
        if (r_count == '0) w_state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_block      = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outstanding count: saturates at both ends; start+end together cancel.
  // Starts while blocked are still counted so the drain stays honest.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else begin
      case ({txn_start_i, txn_end_i})
        2'b10:   if (r_count != CntMax) r_count <= r_count + 1'b1;
        2'b01:   if (r_count != '0)     r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Read mux; reserved field and out-of-range rules read as zero.
  always_comb begin
    w_rd_data = '0;
    if (w_rule_in_range) begin
      case (w_field)
        FIELD_IDX:   w_rd_data = AddrWidth'(r_sh_idx[cfg_rule_i]);
        FIELD_START: w_rd_data = r_sh_start[cfg_rule_i];
        FIELD_END:   w_rd_data = r_sh_end[cfg_rule_i];
        default:     w_rd_data = '0;
      endcase
    end
  end

  // Shadow map writes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NoRules; r++) begin
        r_sh_idx[r]   <= '0;
        r_sh_start[r] <= '0;
        r_sh_end[r]   <= '0;
      end
    end else if (w_gnt && cfg_we_i && w_rule_in_range) begin
      case (w_field)
        FIELD_IDX:   r_sh_idx[cfg_rule_i]   <= cfg_wdata_i[IdxWidth-1:0];
        FIELD_START: r_sh_start[cfg_rule_i] <= cfg_wdata_i;
        FIELD_END:   r_sh_end[cfg_rule_i]   <= cfg_wdata_i;
        default:     ;
      endcase
    end
  end

  // Read response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_gnt & ~cfg_we_i;
      r_rdata  <= (w_gnt & ~cfg_we_i) ? w_rd_data : '0;
    end
  end

  // Commit: the active map only ever changes on the edge leaving COMMIT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_map_valid <= 1'b0;
      for (int r = 0; r < NoRules; r++) begin
        r_act_idx[r]   <= '0;
        r_act_start[r] <= '0;
        r_act_end[r]   <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == ST_COMMIT) begin
        if (w_check_ok) begin
          for (int r = 0; r < NoRules; r++) begin
            r_act_idx[r]   <= r_sh_idx[r];
            r_act_start[r] <= r_sh_start[r];
            r_act_end[r]   <= r_sh_end[r];
          end
          r_map_valid <= 1'b1;
          r_done      <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign cfg_gnt_o     = w_gnt;
  assign cfg_rvalid_o  = r_rvalid;
  assign cfg_rdata_o   = r_rdata;
  assign commit_done_o = r_done;
  assign commit_err_o  = r_err;
  assign block_o       = w_block;
  assign map_valid_o   = r_map_valid;
  assign dbg_state_o   = r_state;
  assign dbg_count_o   = r_count;

endmodule

// File: tb/tb_addr_map_ctrl.sv
// Directed bench for addr_map_ctrl at default parameters.
module tb_addr_map_ctrl;
  import addr_map_ctrl_pkg::*;

  localparam int RW = 66;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_req, cfg_we;
  logic [1:0]   cfg_rule, cfg_field;
  logic [31:0]  cfg_wdata;
  logic         cfg_gnt, cfg_rvalid;
  logic [31:0]  cfg_rdata;
  logic         commit_req, commit_done, commit_err;
  logic         txn_start, txn_end, block;
  logic [4*RW-1:0] addr_map;
  logic         map_valid;
  logic [1:0]   dbg_state;
  logic [3:0]   dbg_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addr_map_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_req_i    (cfg_req),
    .cfg_we_i     (cfg_we),
    .cfg_rule_i   (cfg_rule),
    .cfg_field_i  (cfg_field),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_gnt_o    (cfg_gnt),
    .cfg_rvalid_o (cfg_rvalid),
    .cfg_rdata_o  (cfg_rdata),
    .commit_req_i (commit_req),
    .commit_done_o(commit_done),
    .commit_err_o (commit_err),
    .txn_start_i  (txn_start),
    .txn_end_i    (txn_end),
    .block_o      (block),
    .addr_map_o   (addr_map),
    .map_valid_o  (map_valid),
    .dbg_state_o  (dbg_state),
    .dbg_count_o  (dbg_count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] rule_at(input int r);
    return addr_map[r*RW +: RW];
  endfunction

  task automatic cfg_write(input logic [1:0] rule, input logic [1:0] field, input logic [31:0] data);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_rule = rule; cfg_field = field; cfg_wdata = data;
    tick();
    cfg_req = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input string tag, input logic [1:0] rule, input logic [1:0] field,
                          input logic [31:0] exp);
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_rule = rule; cfg_field = field;
    tick();
    cfg_req = 1'b0;
    check({tag, "_rvalid"}, cfg_rvalid, 1'b1);
    check({tag, "_rdata"}, cfg_rdata, exp);
  endtask

  initial begin
    rst = 1'b1; cfg_req = 1'b1; cfg_we = 1'b0; cfg_rule = '0; cfg_field = '0;
    cfg_wdata = '0; commit_req = 1'b0; txn_start = 1'b0; txn_end = 1'b0;
    tick(); tick();
    // Reset state
    check("rst_gnt", cfg_gnt, 1'b0);
    check("rst_rvalid", cfg_rvalid, 1'b0);
    check("rst_done", commit_done, 1'b0);
    check("rst_err", commit_err, 1'b0);
    check("rst_block", block, 1'b0);
    check("rst_map_valid", map_valid, 1'b0);
    check("rst_map", addr_map, '0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0; cfg_req = 1'b0;
    tick();

    // Build a fully valid shadow map; idx write is truncated to 2 bits
    cfg_write(2'd0, FIELD_IDX, 32'h5);
    cfg_read("idx_trunc", 2'd0, FIELD_IDX, 32'h1);
    cfg_write(2'd0, FIELD_START, 32'h1000);
    cfg_write(2'd0, FIELD_END, 32'h2000);
    for (int r = 1; r < 4; r++) begin
      cfg_write(2'(r), FIELD_IDX, 32'(r));
      cfg_write(2'(r), FIELD_START, 32'h4000 + 32'(r) * 32'h100);
      cfg_write(2'(r), FIELD_END, 32'h4080 + 32'(r) * 32'h100);
    end
    cfg_read("rsvd_field", 2'd0, FIELD_RSVD, 32'h0);
    cfg_read("end_rule3", 2'd3, FIELD_END, 32'h4380);

    // Commit with nothing outstanding
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    check("c1_state_drain", dbg_state, ST_DRAIN);
    check("c1_block_drain", block, 1'b1);
    check("c1_map_hold", addr_map, '0);
    tick();
    check("c1_state_commit", dbg_state, ST_COMMIT);
    check("c1_done_early", commit_done, 1'b0);
    tick();
    check("c1_done", commit_done, 1'b1);
    check("c1_err", commit_err, 1'b0);
    check("c1_map_valid", map_valid, 1'b1);
    check("c1_rule0", rule_at(0), {2'd1, 32'h1000, 32'h2000});
    check("c1_rule2", rule_at(2), {2'd2, 32'h4200, 32'h4280});
    check("c1_block_idle", block, 1'b0);
    tick();
    check("c1_done_pulse", commit_done, 1'b0);

    // Commit waits for the drain
    txn_start = 1'b1; repeat (3) tick(); txn_start = 1'b0;
    check("d_count3", dbg_count, 4'd3);
    check("d_block_idle", block, 1'b0);
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    check("d_state", dbg_state, ST_DRAIN);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_rule = 2'd0; cfg_field = FIELD_START;
    cfg_wdata = 32'hDEAD; txn_start = 1'b1; commit_req = 1'b1;
    #1;
    check("d_gnt", cfg_gnt, 1'b0);
    tick();
    cfg_req = 1'b0; cfg_we = 1'b0; txn_start = 1'b0; commit_req = 1'b0;
    check("d_count_violation", dbg_count, 4'd4);
    check("d_block", block, 1'b1);
    txn_end = 1'b1; repeat (4) tick(); txn_end = 1'b0;
    check("d_count0", dbg_count, 4'd0);
    check("d_still_drain", dbg_state, ST_DRAIN);
    tick();
    check("d_commit", dbg_state, ST_COMMIT);
    tick();
    check("d_done", commit_done, 1'b1);
    check("d_idle", dbg_state, ST_IDLE);
    tick();
    check("d_no_retrigger", dbg_state, ST_IDLE);
    cfg_read("d_shadow_kept", 2'd0, FIELD_START, 32'h1000);

    // Invalid map is rejected
    cfg_write(2'd1, FIELD_START, 32'h3000);
    cfg_write(2'd1, FIELD_END, 32'h3000);
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    tick(); tick();
    check("e_err", commit_err, 1'b1);
    check("e_done", commit_done, 1'b0);
    check("e_map_valid", map_valid, 1'b1);
    check("e_rule1_kept", rule_at(1), {2'd1, 32'h4100, 32'h4180});
    tick();
    check("e_err_pulse", commit_err, 1'b0);

    // Counter saturation and blocking in IDLE
    txn_start = 1'b1;
    repeat (7) tick();
    check("s_count7", dbg_count, 4'd7);
    check("s_block7", block, 1'b0);
    tick();
    check("s_count8", dbg_count, 4'd8);
    check("s_block8", block, 1'b1);
    tick();
    check("s_sat", dbg_count, 4'd8);
    txn_end = 1'b1; tick();
    check("s_both", dbg_count, 4'd8);
    txn_start = 1'b0;
    repeat (8) tick();
    check("s_drained", dbg_count, 4'd0);
    check("s_unblock", block, 1'b0);
    tick();
    check("s_floor", dbg_count, 4'd0);
    txn_end = 1'b0;

    // Reset in the middle of a drain
    txn_start = 1'b1; repeat (2) tick(); txn_start = 1'b0;
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    check("r_drain", dbg_state, ST_DRAIN);
    cfg_req = 1'b1; rst = 1'b1;
    #1;
    check("r_gnt", cfg_gnt, 1'b0);
    check("r_block", block, 1'b0);
    check("r_state", dbg_state, ST_IDLE);
    check("r_map", addr_map, '0);
    check("r_map_valid", map_valid, 1'b0);
    check("r_count", dbg_count, 4'd0);
    check("r_done", commit_done, 1'b0);
    check("r_err", commit_err, 1'b0);
    check("r_rvalid", cfg_rvalid, 1'b0);
    #2;
    rst = 1'b0; cfg_req = 1'b0;
    tick(); tick();
    check("r_discard", dbg_state, ST_IDLE);
    check("r_discard_done", commit_done, 1'b0);
    cfg_read("r_shadow_clr", 2'd0, FIELD_START, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
